// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave backed by a single-port synchronous SRAM
//
// Purpose: terminates one AHB-Lite output and serves it from a 32-bit-wide
// single-port SRAM. Reads and writes run with zero wait states. A read issued
// while the previous write's data phase is using the SRAM gets one wait state.
// Illegal accesses get a two-cycle ERROR response.
//
// Ports:
//   clock, reset_n          clock (rising edge) and asynchronous active-low reset
//   hready                  bus-level ready; address phase sampled only when 1
//   htrans, hsize, hwrite,  AHB address-phase controls and byte address
//   haddr
//   hwdata                  write data (data phase)
//   hreadyout, hresp,       slave ready, response (0 OKAY / 1 ERROR), read data
//   hrdata
//   mem_en, mem_wen,        SRAM strobe, write qualifier, word index,
//   mem_addr, mem_wmask,    byte write enables, write data
//   mem_wdata
//   mem_rdata               SRAM read data, one cycle after a read strobe
module ahb_sram_slave #(
   parameter int          MEM_WORDS = 1024,
   parameter logic [29:0] BASE_ADDR = 30'h0,
   localparam int         AW        = $clog2(MEM_WORDS)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          hready,
   output logic          hreadyout,
   input  logic [1:0]    htrans,
   input  logic [2:0]    hsize,
   input  logic          hwrite,
   input  logic [29:0]   haddr,
   input  logic [31:0]   hwdata,
   output logic          hresp,
   output logic [31:0]   hrdata,
   output logic          mem_en,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_wmask,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_DP, S_RD_DP, S_RD_STALL, S_ERR1, S_ERR2
   } state_t;

   localparam logic [31:0] BASE32  = {2'b00, BASE_ADDR};
   localparam logic [31:0] LIMIT32 = BASE32 + 32'(MEM_WORDS) * 32'd4;

   state_t        state_q, state_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic [3:0]    wmask_q, wmask_d;

   logic          aligned, legal, ready_int, accept, rd_now;
   logic [3:0]    mask_calc;
   logic [AW-1:0] word_idx;
   logic          unused_htrans_seq;

   // NONSEQ and SEQ are treated alike; only htrans[1] matters.
   assign unused_htrans_seq = htrans[0];

   assign word_idx = AW'((haddr - BASE_ADDR) >> 2);

   always_comb begin
      aligned = 1'b0;
      case (hsize)
         3'd0:    aligned = 1'b1;
         3'd1:    aligned = ~haddr[0];
         3'd2:    aligned = (haddr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   always_comb begin
      mask_calc = 4'b1111;
      case (hsize[1:0])
         2'd0:    mask_calc = 4'b0001 << haddr[1:0];
         2'd1:    mask_calc = 4'b0011 << haddr[1:0];
         default: mask_calc = 4'b1111;
      endcase
   end

   assign legal = (hsize <= 3'd2) && aligned &&
                  ({2'b00, haddr} >= BASE32) && ({2'b00, haddr} < LIMIT32);

   // Only states that complete their data phase this cycle may take a new address phase.
   assign ready_int = (state_q != S_ERR1) && (state_q != S_RD_STALL);
   assign accept    = hready && htrans[1] && ready_int;
   // A read goes straight to the SRAM unless a write data phase owns it this cycle.
   // Gated by reset_n so no strobe escapes while reset is asserted.
   assign rd_now    = reset_n && accept && legal && !hwrite && (state_q != S_WR_DP);

   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      raddr_d = raddr_q;
      wmask_d = wmask_q;
      if (accept) begin
         if (!legal) begin
            state_d = S_ERR1;
         end else if (hwrite) begin
            state_d = S_WR_DP;
            waddr_d = word_idx;
            wmask_d = mask_calc;
         end else if (state_q == S_WR_DP) begin
            state_d = S_RD_STALL;
            raddr_d = word_idx;
         end else begin
            state_d = S_RD_DP;
         end
      end else begin
         case (state_q)
            S_ERR1:     state_d = S_ERR2;
            S_RD_STALL: state_d = S_RD_DP;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         waddr_q <= '0;
         raddr_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         raddr_q <= raddr_d;
         wmask_q <= wmask_d;
      end
   end

   assign hreadyout = ready_int;
   assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign hrdata    = (state_q == S_RD_DP) ? mem_rdata : 32'h0;

   assign mem_en    = (state_q == S_WR_DP) || (state_q == S_RD_STALL) || rd_now;
   assign mem_wen   = (state_q == S_WR_DP);
   assign mem_wmask = (state_q == S_WR_DP) ? wmask_q : 4'h0;
   assign mem_wdata = (state_q == S_WR_DP) ? hwdata : 32'h0;

   always_comb begin
      mem_addr = '0;
      if (state_q == S_WR_DP)         mem_addr = waddr_q;
      else if (state_q == S_RD_STALL) mem_addr = raddr_q;
      else if (rd_now)                mem_addr = word_idx;
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        hready, hready_low;
   logic        hreadyout;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [29:0] haddr;
   logic [31:0] hwdata;
   logic        hresp;
   logic [31:0] hrdata;
   logic        mem_en, mem_wen;
   logic [9:0]  mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   logic [31:0] mem [0:1023];

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   assign hready = hreadyout & ~hready_low;

   ahb_sram_slave #(.MEM_WORDS(1024), .BASE_ADDR(30'h0)) dut (
      .clock(clock), .reset_n(reset_n), .hready(hready), .hreadyout(hreadyout),
      .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .haddr(haddr),
      .hwdata(hwdata), .hresp(hresp), .hrdata(hrdata), .mem_en(mem_en),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // SRAM model: word i preloaded with 0xA5000000 | i
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
      forever begin
         @(posedge clock);
         if (mem_en) begin
            if (mem_wen) begin
               for (int b = 0; b < 4; b++)
                  if (mem_wmask[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
               mem_rdata <= mem[mem_addr];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic addr_phase(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                             input logic [29:0] a);
      htrans = tr; hwrite = wr; hsize = sz; haddr = a;
   endtask

   task automatic next_cycle();
      @(posedge clock); #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   logic [2:0]  err_sz [3];
   logic [29:0] err_a  [3];
   logic        err_wr [3];

   initial begin
      err_sz[0] = 3'd3; err_a[0] = 30'h0;    err_wr[0] = 1'b0;
      err_sz[1] = 3'd1; err_a[1] = 30'h1;    err_wr[1] = 1'b1;
      err_sz[2] = 3'd2; err_a[2] = 30'h1000; err_wr[2] = 1'b0;

      reset_n = 1'b0; hready_low = 1'b0; hwdata = 32'h0;
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      #2;
      check("rst_hreadyout", hreadyout, 1);
      check("rst_hresp",     hresp, 0);
      check("rst_hrdata",    hrdata, 0);
      check("rst_mem_en",    mem_en, 0);
      check("rst_mem_wen",   mem_wen, 0);
      check("rst_mem_wmask", mem_wmask, 0);
      check("rst_mem_addr",  mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // 1: reset during a write data phase drops the write
      addr_phase(T_NSEQ, 1'b1, 3'd2, 30'h30);
      next_cycle();
      hwdata = 32'h1234_5678;
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      #1;
      check("t1_wen_before", mem_wen, 1);
      reset_n = 1'b0;
      #1;
      check("t1_wen_in_rst", mem_wen, 0);
      check("t1_en_in_rst",  mem_en, 0);
      check("t1_rdy_in_rst", hreadyout, 1);
      check("t1_resp_in_rst", hresp, 0);
      next_cycle();
      reset_n = 1'b1;
      hwdata = 32'h0;
      next_cycle();
      addr_phase(T_NSEQ, 1'b0, 3'd2, 30'h30);
      mid();
      check("t1_rd_en",   mem_en, 1);
      check("t1_rd_addr", mem_addr, 12);
      next_cycle();
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      mid();
      check("t1_word_kept", hrdata, 32'hA500_000C);
      next_cycle();

      // 2: write 0x10 then immediate read 0x20 -> one wait state
      addr_phase(T_NSEQ, 1'b1, 3'd2, 30'h10);
      mid();
      check("t2_wr_ap_noen", mem_en, 0);
      next_cycle();
      hwdata = 32'hDEAD_BEEF;
      addr_phase(T_NSEQ, 1'b0, 3'd2, 30'h20);
      mid();
      check("t2_wr_en",    mem_en, 1);
      check("t2_wr_wen",   mem_wen, 1);
      check("t2_wr_addr",  mem_addr, 4);
      check("t2_wr_mask",  mem_wmask, 4'hF);
      check("t2_wr_data",  mem_wdata, 32'hDEAD_BEEF);
      check("t2_wr_rdy",   hreadyout, 1);
      next_cycle();
      hwdata = 32'h0;
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      mid();
      check("t2_stall_rdy",  hreadyout, 0);
      check("t2_stall_en",   mem_en, 1);
      check("t2_stall_wen",  mem_wen, 0);
      check("t2_stall_addr", mem_addr, 8);
      next_cycle();
      mid();
      check("t2_rd_rdy",  hreadyout, 1);
      check("t2_rd_data", hrdata, 32'hA500_0008);
      next_cycle();
      addr_phase(T_NSEQ, 1'b0, 3'd2, 30'h10);
      next_cycle();
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      mid();
      check("t2_readback", hrdata, 32'hDEAD_BEEF);
      next_cycle();

      // 3: back-to-back reads, zero wait
      addr_phase(T_NSEQ, 1'b0, 3'd2, 30'h0);
      mid();
      check("t3_en0",   mem_en, 1);
      check("t3_addr0", mem_addr, 0);
      next_cycle();
      addr_phase(T_SEQ, 1'b0, 3'd2, 30'h4);
      mid();
      check("t3_rdy0",  hreadyout, 1);
      check("t3_data0", hrdata, 32'hA500_0000);
      check("t3_addr1", mem_addr, 1);
      next_cycle();
      addr_phase(T_SEQ, 1'b0, 3'd2, 30'h8);
      mid();
      check("t3_rdy1",  hreadyout, 1);
      check("t3_data1", hrdata, 32'hA500_0001);
      next_cycle();
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      mid();
      check("t3_rdy2",  hreadyout, 1);
      check("t3_data2", hrdata, 32'hA500_0002);
      next_cycle();
      mid();
      check("t3_idle_data", hrdata, 0);

      // 4: byte write @0x13, halfword write @0x16
      next_cycle();
      addr_phase(T_NSEQ, 1'b1, 3'd0, 30'h13);
      next_cycle();
      hwdata = 32'h5500_0000;
      addr_phase(T_NSEQ, 1'b1, 3'd1, 30'h16);
      mid();
      check("t4_b_mask", mem_wmask, 4'b1000);
      check("t4_b_addr", mem_addr, 4);
      next_cycle();
      hwdata = 32'hAAAA_0000;
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      mid();
      check("t4_h_mask", mem_wmask, 4'b1100);
      check("t4_h_addr", mem_addr, 5);
      check("t4_h_wen",  mem_wen, 1);
      next_cycle();
      hwdata = 32'h0;
      addr_phase(T_NSEQ, 1'b0, 3'd2, 30'h10);
      next_cycle();
      addr_phase(T_NSEQ, 1'b0, 3'd2, 30'h14);
      mid();
      check("t4_word4", hrdata, 32'h55AD_BEEF);
      next_cycle();
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      mid();
      check("t4_word5", hrdata, 32'hAAAA_0005);
      next_cycle();

      // 5: illegal accesses -> two-cycle ERROR, no SRAM access
      for (int k = 0; k < 3; k++) begin
         addr_phase(T_NSEQ, err_wr[k], err_sz[k], err_a[k]);
         mid();
         check($sformatf("t5_%0d_ap_en", k), mem_en, 0);
         next_cycle();
         addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
         mid();
         check($sformatf("t5_%0d_e1_rdy", k), hreadyout, 0);
         check($sformatf("t5_%0d_e1_resp", k), hresp, 1);
         check($sformatf("t5_%0d_e1_en", k), mem_en, 0);
         next_cycle();
         mid();
         check($sformatf("t5_%0d_e2_rdy", k), hreadyout, 1);
         check($sformatf("t5_%0d_e2_resp", k), hresp, 1);
         check($sformatf("t5_%0d_e2_en", k), mem_en, 0);
         next_cycle();
         mid();
         check($sformatf("t5_%0d_after_resp", k), hresp, 0);
         next_cycle();
      end

      // 6: BUSY then IDLE
      addr_phase(T_BUSY, 1'b0, 3'd2, 30'h0);
      mid();
      check("t6_busy_rdy",  hreadyout, 1);
      check("t6_busy_resp", hresp, 0);
      check("t6_busy_en",   mem_en, 0);
      next_cycle();
      addr_phase(T_IDLE, 1'b0, 3'd2, 30'h4);
      mid();
      check("t6_idle_rdy",  hreadyout, 1);
      check("t6_idle_resp", hresp, 0);
      check("t6_idle_en",   mem_en, 0);
      next_cycle();
      mid();
      check("t6_after_en", mem_en, 0);

      // hready low in IDLE: address phase is ignored
      next_cycle();
      hready_low = 1'b1;
      addr_phase(T_NSEQ, 1'b1, 3'd2, 30'h0);
      mid();
      check("t7_noacc_en", mem_en, 0);
      next_cycle();
      hready_low = 1'b0;
      hwdata = 32'hFFFF_FFFF;
      addr_phase(T_IDLE, 1'b0, 3'd0, 30'h0);
      mid();
      check("t7_noacc_wen", mem_wen, 0);
      check("t7_noacc_rdy", hreadyout, 1);
      next_cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
